// File: rtl/mw_writeback_pkg.sv
// Shared encodings for the stage-3 memory/writeback slice: writeback selects,
// load/store funct3 codes, the tohost CSR address and the FSM state type.
package mw_writeback_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [11:0] TOHOST_ADDR_DEFAULT = 12'h51E;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_RESP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/mw_writeback_load_extract.sv
// Load data extraction: shifts the memory word down by the byte offset and
// sign/zero-extends it according to funct3.
module mw_writeback_load_extract
    import mw_writeback_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {off, 3'b000};
        case (funct3)
            F3_LB:   value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   value = shifted;
            F3_LBU:  value = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mw_writeback.sv
// Stage-3 memory/writeback: drives the data-memory handshake, stalls upstream
// while memory is outstanding, and registers the register-file write and tohost.
module mw_writeback
    import mw_writeback_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr,
    input  logic [3:0]      w_mask,
    input  logic            re,
    input  logic [1:0]      wb_sel,
    input  logic            rwe,
    input  logic            csr_we,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] tohost
);

    // Handshake: a request transfers on any cycle where mem_req_valid and
    // mem_req_ready are both high; the request fields stay stable until then
    // because in_valid and the stage-3 operands are frozen by stall. A load
    // response transfers on the single cycle mem_resp_valid is high in WAIT_RESP.

    wb_state_t state;  // visible for checker binding

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic [1:0]      off;
    logic [7:0]      wmask_wide;
    logic            retire;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] wb_value;

    assign is_load    = in_valid & re;
    assign is_store   = in_valid & (w_mask != 4'b0000);
    assign mem_op     = is_load | is_store;
    assign off        = alu_result[1:0];

    assign mem_addr   = {alu_result[XLEN-1:2], 2'b00};
    assign wmask_wide = {4'b0000, w_mask} << off;
    assign mem_wmask  = wmask_wide[3:0];
    assign mem_wdata  = store_data << {off, 3'b000};

    always_comb begin
        mem_req_valid = 1'b0;
        stall         = 1'b0;
        if (state == ST_WAIT_RESP) begin
            stall = ~mem_resp_valid;
        end else begin
            mem_req_valid = mem_op;
            // A store completes on its handshake; a load must wait for data.
            stall         = mem_op & ~(is_store & mem_req_ready);
        end
    end

    assign retire = in_valid & ~stall;

    mw_writeback_load_extract #(.XLEN(XLEN)) u_load_extract (
        .word   (mem_resp_data),
        .off    (off),
        .funct3 (funct3),
        .value  (load_value)
    );

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_value = load_value;
            WB_PC4:  wb_value = pc + XLEN'(4);
            default: wb_value = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
            tohost   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (is_load & ~is_store & mem_req_ready) begin
                    state <= ST_WAIT_RESP;
                end
            end else if (mem_resp_valid) begin
                state <= ST_IDLE;
            end

            rf_we <= retire & rwe & (rd != 5'd0);
            if (retire) begin
                rf_waddr <= rd;
                rf_wdata <= wb_value;
                if (csr_we && (csr == TOHOST_ADDR)) begin
                    tohost <= csr_wdata;
                end
            end
        end
    end

endmodule
